// File: rtl/fft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// fft_stage_sequencer
//
// Control sequencer for an in-place radix-2 decimation-in-time FFT of
// N = 2^LOG2N points. It steps through the LOG2N stages and, within each
// stage, through the N/2 butterflies. For every butterfly it produces the
// sample-RAM address pair and the twiddle-ROM address. Between stages it waits
// BFLY_LAT cycles so that the butterfly pipeline can drain before the next
// stage reads results that the previous stage wrote back.
//
// Ports
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_start       start request, honoured only while idle
//   i_stall       holds butterfly issue while running (ignored while draining)
//   i_abort       synchronous abort back to idle; beats every other request
//   o_busy        high while running or draining
//   o_issue       butterfly valid this cycle; qualifies the address outputs
//   o_stage       current stage index
//   o_bfly_idx    butterfly index within the stage, 0..N/2-1
//   o_addr_a      upper-leg sample address
//   o_addr_b      lower-leg sample address
//   o_tw_addr     twiddle ROM address
//   o_mux_sel     low two bits of the stage index for the datapath muxes
//   o_cycle_done  one-cycle pulse when a transform completes
//   o_frame_cnt   number of completed transforms, wraps 255 -> 0
// -----------------------------------------------------------------------------
module fft_stage_sequencer #(
    parameter int LOG2N    = 4,
    parameter int BFLY_LAT = 2,
    localparam int SW      = ($clog2(LOG2N) > 1) ? $clog2(LOG2N) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_stall,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_issue,
    output logic [SW-1:0]    o_stage,
    output logic [LOG2N-2:0] o_bfly_idx,
    output logic [LOG2N-1:0] o_addr_a,
    output logic [LOG2N-1:0] o_addr_b,
    output logic [LOG2N-2:0] o_tw_addr,
    output logic [1:0]       o_mux_sel,
    output logic             o_cycle_done,
    output logic [7:0]       o_frame_cnt
);

    localparam int IW = LOG2N - 1;

    localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2N - 1);
    localparam logic [IW-1:0] IDX_LAST   = '1;
    localparam logic [IW-1:0] IDX_ONE    = IW'(1);
    localparam logic [SW-1:0] STAGE_ONE  = SW'(1);
    localparam logic [3:0]    DRAIN_LAST = (BFLY_LAT == 0) ? 4'd0 : 4'(BFLY_LAT - 1);
    localparam logic [SW:0]   SH_ONE     = (SW+1)'(1);
    localparam logic [SW:0]   TW_TOP     = (SW+1)'(LOG2N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_reg, state_next;
    logic [SW-1:0]   stage_reg, stage_next;
    logic [IW-1:0]   idx_reg,   idx_next;
    logic [3:0]      drain_reg, drain_next;
    logic [7:0]      frame_reg, frame_next;

    logic            issue_w;
    logic            last_stage_w;

    // Address arithmetic intermediates
    logic [LOG2N-1:0] idx_ext;
    logic [LOG2N-1:0] span_w;
    logic [LOG2N-1:0] pos_mask;
    logic [LOG2N-1:0] pos_w;
    logic [LOG2N-1:0] grp_w;
    logic [SW:0]      grp_sh;
    logic [SW:0]      tw_sh;
    logic [LOG2N-1:0] a_calc;
    logic [LOG2N-1:0] b_calc;
    logic [IW-1:0]    tw_calc;

    assign issue_w      = (state_reg == ST_RUN) && !i_stall;
    assign last_stage_w = (stage_reg == LAST_STAGE);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Stage / butterfly / drain counters and the completed-frame counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stage_reg <= '0;
            idx_reg   <= '0;
            drain_reg <= '0;
            frame_reg <= '0;
        end else begin
            stage_reg <= stage_next;
            idx_reg   <= idx_next;
            drain_reg <= drain_next;
            frame_reg <= frame_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        idx_next   = idx_reg;
        drain_next = drain_reg;
        frame_next = frame_reg;

        if (i_abort) begin
            // Abort drops everything except the completed-frame count.
            state_next = ST_IDLE;
            stage_next = '0;
            idx_next   = '0;
            drain_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        state_next = ST_RUN;
                        stage_next = '0;
                        idx_next   = '0;
                    end
                end

                ST_RUN: begin
                    if (issue_w) begin
                        if (idx_reg == IDX_LAST) begin
                            // idx is left on the last butterfly so the address
                            // outputs keep their final value while draining.
                            if (BFLY_LAT == 0) begin
                                if (last_stage_w) begin
                                    state_next = ST_DONE;
                                    frame_next = frame_reg + 8'd1;
                                end else begin
                                    stage_next = stage_reg + STAGE_ONE;
                                    idx_next   = '0;
                                end
                            end else begin
                                state_next = ST_DRAIN;
                                drain_next = '0;
                            end
                        end else begin
                            idx_next = idx_reg + IDX_ONE;
                        end
                    end
                end

                ST_DRAIN: begin
                    // Stall has no effect here: in-flight butterflies must
                    // complete regardless of issue back-pressure.
                    if (drain_reg == DRAIN_LAST) begin
                        drain_next = '0;
                        if (last_stage_w) begin
                            state_next = ST_DONE;
                            frame_next = frame_reg + 8'd1;
                        end else begin
                            state_next = ST_RUN;
                            stage_next = stage_reg + STAGE_ONE;
                            idx_next   = '0;
                        end
                    end else begin
                        drain_next = drain_reg + 4'd1;
                    end
                end

                ST_DONE: begin
                    // A start seen here is dropped; the next one is taken in idle.
                    state_next = ST_IDLE;
                    stage_next = '0;
                    idx_next   = '0;
                end

                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Address generation from the registered stage and butterfly index.
    // With span = 2^s, the upper leg is the butterfly index with a zero bit
    // inserted at position s; the lower leg sets that bit. The twiddle index
    // is the position within the group scaled to the N/2-entry ROM.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LOG2N; gi++) begin : g_pos_mask
            // Bit gi belongs to the in-group position when gi < s.
            assign pos_mask[gi] = (SW'(gi) < stage_reg);
        end
    endgenerate

    always_comb begin
        idx_ext = {1'b0, idx_reg};
        span_w  = LOG2N'(1) << stage_reg;
        pos_w   = idx_ext & pos_mask;
        grp_w   = idx_ext >> stage_reg;
        // One bit wider than the stage index so s+1 never wraps.
        grp_sh  = {1'b0, stage_reg} + SH_ONE;
        tw_sh   = TW_TOP - {1'b0, stage_reg};
        a_calc  = (grp_w << grp_sh) | pos_w;
        b_calc  = a_calc + span_w;
        tw_calc = pos_w[IW-1:0] << tw_sh;
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        o_busy       = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
        o_issue      = issue_w;
        o_cycle_done = (state_reg == ST_DONE);
        o_stage      = stage_reg;
        o_bfly_idx   = idx_reg;
        if (state_reg == ST_IDLE) begin
            // Idle presents a clean all-zero interface.
            o_addr_a  = '0;
            o_addr_b  = '0;
            o_tw_addr = '0;
        end else begin
            // Stage/idx only move on an issue, so the addresses hold while
            // stalled, draining or in the done cycle.
            o_addr_a  = a_calc;
            o_addr_b  = b_calc;
            o_tw_addr = tw_calc;
        end
    end

    generate
        if (SW == 1) begin : g_mux_narrow
            assign o_mux_sel = {1'b0, stage_reg};
        end else begin : g_mux_wide
            assign o_mux_sel = stage_reg[1:0];
        end
    endgenerate

    assign o_frame_cnt = frame_reg;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
`timescale 1ns/1ps
module tb_fft_stage_sequencer;

    localparam int LA  = 4;
    localparam int BA  = 2;
    localparam int SWA = 2;
    localparam int LB  = 3;
    localparam int BB  = 0;
    localparam int SWB = 2;

    typedef struct {
        int stage;
        int idx;
        int a;
        int b;
        int tw;
    } bfly_t;

    typedef struct {
        int stall_stage;
        int stall_idx;
        int stall_len;
        bit drain_stall;
        int exp_done;
    } run_vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_fcnt_a = 0;

    bfly_t    q_a[$];
    bfly_t    q_b[$];
    bfly_t    spot[3];
    run_vec_t vecs[4];

    // DUT A: 16-point, drain latency 2
    logic              da_rst_n, da_start, da_stall, da_abort;
    logic              da_busy, da_issue, da_done;
    logic [SWA-1:0]    da_stage;
    logic [LA-2:0]     da_idx;
    logic [LA-1:0]     da_addr_a, da_addr_b;
    logic [LA-2:0]     da_tw;
    logic [1:0]        da_mux;
    logic [7:0]        da_fcnt;

    // DUT B: 8-point, no drain
    logic              db_rst_n, db_start, db_stall, db_abort;
    logic              db_busy, db_issue, db_done;
    logic [SWB-1:0]    db_stage;
    logic [LB-2:0]     db_idx;
    logic [LB-1:0]     db_addr_a, db_addr_b;
    logic [LB-2:0]     db_tw;
    logic [1:0]        db_mux;
    logic [7:0]        db_fcnt;

    fft_stage_sequencer #(.LOG2N(LA), .BFLY_LAT(BA)) u_dut_a (
        .i_clk(clk), .i_rst_n(da_rst_n), .i_start(da_start), .i_stall(da_stall), .i_abort(da_abort),
        .o_busy(da_busy), .o_issue(da_issue), .o_stage(da_stage), .o_bfly_idx(da_idx),
        .o_addr_a(da_addr_a), .o_addr_b(da_addr_b), .o_tw_addr(da_tw), .o_mux_sel(da_mux),
        .o_cycle_done(da_done), .o_frame_cnt(da_fcnt)
    );

    fft_stage_sequencer #(.LOG2N(LB), .BFLY_LAT(BB)) u_dut_b (
        .i_clk(clk), .i_rst_n(db_rst_n), .i_start(db_start), .i_stall(db_stall), .i_abort(db_abort),
        .o_busy(db_busy), .o_issue(db_issue), .o_stage(db_stage), .o_bfly_idx(db_idx),
        .o_addr_a(db_addr_a), .o_addr_b(db_addr_b), .o_tw_addr(db_tw), .o_mux_sel(db_mux),
        .o_cycle_done(db_done), .o_frame_cnt(db_fcnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Reference butterfly order: groups of 2*span, position j within a group.
    task automatic push_frame(input int log2n, input bit to_b);
        int    n;
        int    span;
        bfly_t e;
        n = 1 << log2n;
        for (int s = 0; s < log2n; s++) begin
            span = 1 << s;
            for (int g = 0; g < n / (2 * span); g++) begin
                for (int j = 0; j < span; j++) begin
                    e.stage = s;
                    e.idx   = g * span + j;
                    e.a     = g * 2 * span + j;
                    e.b     = e.a + span;
                    e.tw    = j * (n / (2 * span));
                    if (to_b) q_b.push_back(e);
                    else      q_a.push_back(e);
                end
            end
        end
    endtask

    task automatic sb_compare(input bit use_b, input logic [31:0] s, input logic [31:0] i,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] tw, input logic [31:0] mux);
        bfly_t e;
        bit    empty;
        n_checks++;
        empty = use_b ? (q_b.size() == 0) : (q_a.size() == 0);
        if (empty) begin
            n_fail++;
            $display("FAIL %s: got issue s=%0d idx=%0d, required no issue", use_b ? "sb_b" : "sb_a", s, i);
        end else begin
            if (use_b) e = q_b.pop_front();
            else       e = q_a.pop_front();
            if (s !== e.stage || i !== e.idx || a !== e.a || b !== e.b || tw !== e.tw || mux !== (e.stage & 3)) begin
                n_fail++;
                $display("FAIL %s: got s=%0d idx=%0d a=%0d b=%0d tw=%0d mux=%0d, required s=%0d idx=%0d a=%0d b=%0d tw=%0d mux=%0d",
                         use_b ? "sb_b" : "sb_a", s, i, a, b, tw, mux,
                         e.stage, e.idx, e.a, e.b, e.tw, e.stage & 3);
            end
            if (!use_b) begin
                for (int k = 0; k < 3; k++) begin
                    if (spot[k].stage == e.stage && spot[k].idx == e.idx) begin
                        check("spot_addr_a", a, spot[k].a);
                        check("spot_addr_b", b, spot[k].b);
                        check("spot_tw", tw, spot[k].tw);
                    end
                end
            end
        end
    endtask

    task automatic sb_a_now();
        sb_compare(1'b0, 32'(da_stage), 32'(da_idx), 32'(da_addr_a), 32'(da_addr_b), 32'(da_tw), 32'(da_mux));
    endtask

    task automatic check_a_idle_zero(input string tag);
        check({tag, "_busy"},  da_busy, 0);
        check({tag, "_issue"}, da_issue, 0);
        check({tag, "_stage"}, da_stage, 0);
        check({tag, "_idx"},   da_idx, 0);
        check({tag, "_addr_a"}, da_addr_a, 0);
        check({tag, "_addr_b"}, da_addr_b, 0);
        check({tag, "_tw"},    da_tw, 0);
        check({tag, "_mux"},   da_mux, 0);
        check({tag, "_done"},  da_done, 0);
    endtask

    // One full 16-point transform with optional stall windows.
    task automatic run_a(input run_vec_t v);
        int cyc, stall_rem, drain_rem, issues, done_cyc;
        bit trig;
        cyc = 0; stall_rem = 0; drain_rem = 0; issues = 0; done_cyc = -1; trig = 1'b0;
        push_frame(LA, 1'b0);
        @(posedge clk); #1; da_start = 1'b1;
        @(posedge clk); #1; da_start = 1'b0; cyc = 1;
        while (done_cyc < 0 && cyc <= 200) begin
            da_stall = 1'b0;
            if (stall_rem > 0) begin
                da_stall = 1'b1; stall_rem--;
            end else if (!trig && v.stall_len > 0 && da_busy === 1'b1 &&
                         int'(da_stage) == v.stall_stage && int'(da_idx) == v.stall_idx) begin
                trig = 1'b1; da_stall = 1'b1; stall_rem = v.stall_len - 1;
            end else if (drain_rem > 0) begin
                da_stall = 1'b1; drain_rem--;
            end
            // Start pulses while busy and in the done cycle must be ignored.
            da_start = (cyc == 5 || cyc == 20 || cyc == v.exp_done);
            @(negedge clk);
            if (da_stall) check("stall_no_issue", da_issue, 0);
            if (da_issue === 1'b1) begin
                issues++;
                sb_a_now();
                if (v.drain_stall && int'(da_stage) == v.stall_stage && int'(da_idx) == (1 << (LA - 1)) - 1)
                    drain_rem = BA;
            end
            if (da_done === 1'b1) begin
                done_cyc = cyc;
                exp_fcnt_a = (exp_fcnt_a + 1) % 256;
                check("done_busy_low", da_busy, 0);
                check("frame_cnt", da_fcnt, exp_fcnt_a);
            end
            @(posedge clk); #1; cyc++;
        end
        da_start = 1'b0;
        da_stall = 1'b0;
        check("done_cycle", done_cyc, v.exp_done);
        check("issue_count", issues, 32);
        check("sb_a_drained", q_a.size(), 0);
        @(negedge clk);
        check("done_one_pulse", da_done, 0);
        check("post_done_busy", da_busy, 0);
        check("post_done_addr_b", da_addr_b, 0);
        check("post_done_mux", da_mux, 0);
        check("post_done_fcnt", da_fcnt, exp_fcnt_a);
        $display("run stall_stage=%0d idx=%0d len=%0d drain=%0d: done cycle %0d, issues %0d",
                 v.stall_stage, v.stall_idx, v.stall_len, v.drain_stall, done_cyc, issues);
        q_a.delete();
    endtask

    task automatic abort_a();
        int cyc;
        bit hit, bad;
        push_frame(LA, 1'b0);
        @(posedge clk); #1; da_start = 1'b1;
        @(posedge clk); #1; da_start = 1'b0; cyc = 1; hit = 1'b0;
        while (!hit && cyc <= 100) begin
            if (da_busy === 1'b1 && int'(da_stage) == 1 && int'(da_idx) == 4) begin
                da_abort = 1'b1; hit = 1'b1;
            end
            @(negedge clk);
            if (da_issue === 1'b1) sb_a_now();
            if (da_done === 1'b1) check("abort_early_done", da_done, 0);
            @(posedge clk); #1; cyc++;
        end
        da_abort = 1'b0;
        check("abort_point_reached", hit, 1);
        @(negedge clk);
        check_a_idle_zero("abort");
        check("abort_fcnt_kept", da_fcnt, exp_fcnt_a);
        bad = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (da_done !== 1'b0 || da_busy !== 1'b0) bad = 1'b1;
        end
        check("abort_stays_idle", bad, 0);
        $display("abort at stage 1 idx 4: frame_cnt %0d", da_fcnt);
        q_a.delete();
    endtask

    task automatic areset_a();
        int cyc;
        bit bad;
        push_frame(LA, 1'b0);
        @(posedge clk); #1; da_start = 1'b1;
        @(posedge clk); #1; da_start = 1'b0; cyc = 1;
        while (!(da_busy === 1'b1 && int'(da_stage) == 1 && int'(da_idx) == 2) && cyc <= 100) begin
            @(negedge clk);
            if (da_issue === 1'b1) sb_a_now();
            @(posedge clk); #1; cyc++;
        end
        check("areset_point_reached", (cyc <= 100), 1);
        #2 da_rst_n = 1'b0;
        #1;
        exp_fcnt_a = 0;
        check_a_idle_zero("areset");
        check("areset_fcnt", da_fcnt, 0);
        @(negedge clk); #1 da_rst_n = 1'b1;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (da_busy !== 1'b0 || da_issue !== 1'b0) bad = 1'b1;
        end
        check("areset_idle_after", bad, 0);
        $display("async reset mid-run: frame_cnt %0d busy %0d", da_fcnt, da_busy);
        q_a.delete();
    endtask

    task automatic continuous_b();
        int cyc, frames, phase;
        frames = 0;
        push_frame(LB, 1'b1);
        @(posedge clk); #1; db_start = 1'b1;
        @(posedge clk); #1; cyc = 1;
        while (frames < 256 && cyc <= 4000) begin
            @(negedge clk);
            phase = (cyc - 1) % 14;
            check("b_issue", db_issue, (phase < 12));
            check("b_done", db_done, (phase == 12));
            if (db_issue === 1'b1)
                sb_compare(1'b1, 32'(db_stage), 32'(db_idx), 32'(db_addr_a), 32'(db_addr_b), 32'(db_tw), 32'(db_mux));
            if (db_done === 1'b1) begin
                frames++;
                check("b_frame_cnt", db_fcnt, frames % 256);
                if (frames < 256) push_frame(LB, 1'b1);
                if (frames <= 2 || frames >= 255)
                    $display("dut_b frame %0d done at cycle %0d, frame_cnt %0d", frames, cyc, db_fcnt);
            end
            @(posedge clk); #1; cyc++;
        end
        db_start = 1'b0;
        check("b_frames", frames, 256);
        check("b_fcnt_wrap", db_fcnt, 0);
        check("sb_b_drained", q_b.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        spot[0] = '{0, 5, 10, 11, 0};
        spot[1] = '{1, 3, 5, 7, 4};
        spot[2] = '{3, 5, 5, 13, 5};

        vecs[0] = '{-1, 0, 0, 1'b0, 41};
        vecs[1] = '{ 2, 3, 3, 1'b1, 44};
        vecs[2] = '{ 0, 0, 1, 1'b1, 42};
        vecs[3] = '{ 3, 7, 2, 1'b0, 43};

        da_rst_n = 1'b0; da_start = 1'b0; da_stall = 1'b0; da_abort = 1'b0;
        db_rst_n = 1'b0; db_start = 1'b0; db_stall = 1'b0; db_abort = 1'b0;

        repeat (2) @(negedge clk);
        check_a_idle_zero("reset");
        check("reset_fcnt_a", da_fcnt, 0);
        check("reset_busy_b", db_busy, 0);
        check("reset_fcnt_b", db_fcnt, 0);
        @(posedge clk); #1;
        da_rst_n = 1'b1;
        db_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", da_busy, 0);

        for (int v = 0; v < 4; v++) run_a(vecs[v]);
        abort_a();
        run_a(vecs[0]);
        areset_a();
        run_a(vecs[0]);
        continuous_b();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
Parametrised control sequencer for an in-place radix-2 DIT FFT of 2^LOG2N points. It supersedes the fixed 4-stage mux-select counter. It walks every stage and every butterfly within the stage, generating the memory address pair and twiddle address for each butterfly. It inserts pipeline drain gaps between stages and handles the start/busy/done, stall and abort controls. It sits between the top-level frame controller and the butterfly datapath and sample RAM.

Parameters:
LOG2N, 4, log2 of transform size; number of stages = LOG2N; N = 2^LOG2N; legal 2..10
BFLY_LAT, 2, butterfly pipeline latency in cycles, drained after each stage; legal 0..15
SW, derived = max(1, clog2(LOG2N)), stage index width (not user-set)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_start  in  1  start request; sampled only in IDLE
i_stall  in  1  hold butterfly issue (RUN only)
i_abort  in  1  synchronous abort; highest priority after reset
o_busy  out  1  high in RUN and DRAIN
o_issue  out  1  butterfly valid this cycle; address outputs are valid when high
o_stage  out  SW  current stage s
o_bfly_idx  out  LOG2N-1  butterfly index within stage, 0..N/2-1
o_addr_a  out  LOG2N  upper-leg sample address
o_addr_b  out  LOG2N  lower-leg sample address
o_tw_addr  out  LOG2N-1  twiddle ROM address
o_mux_sel  out  2  o_stage[1:0], zero-extended if SW=1; keeps the existing datapath mux hookup
o_cycle_done  out  1  one-cycle pulse when a transform completes
o_frame_cnt  out  8  completed-transform count; wraps 255->0

Behaviour:
- Reset (i_rst_n low, async): state IDLE. All outputs 0, including o_frame_cnt.
- States:
  - IDLE: on i_start=1 -> RUN with stage=0, idx=0.
  - RUN: o_issue = !i_stall. Idx increments only when o_issue=1. At idx = N/2-1 with issue -> DRAIN (or, if BFLY_LAT=0, straight to the next stage or DONE).
  - DRAIN: counts exactly BFLY_LAT cycles; i_stall is ignored. Then: if stage < LOG2N-1, stage++, idx=0, RUN; else DONE.
  - DONE: lasts exactly 1 cycle. o_cycle_done=1, o_busy=0, o_frame_cnt increments. -> IDLE.
- i_start outside IDLE (including the DONE cycle) is ignored. Start held high continuously gives back-to-back transforms separated by the DONE cycle plus one IDLE cycle.
- i_abort=1 in any state -> IDLE next cycle. All counters clear, no o_cycle_done pulse, o_frame_cnt unchanged.
- Address arithmetic (combinational from registered stage/idx), with span = 2^s, group = idx >> s, pos = idx & (span-1):
  - a = group*2*span + pos
  - b = a + span
  - tw = pos << (LOG2N-1-s)
  - All results are unsigned and truncated to port width; no overflow occurs for legal ranges.
- Address outputs hold their last value when o_issue=0. The downstream logic qualifies them with o_issue.
- Latency: the first o_issue is in the cycle after the clock edge that samples i_start. Cycle count from that edge to o_cycle_done = LOG2N*(N/2 + BFLY_LAT) + 1 + total stall cycles.
- o_mux_sel follows o_stage in all states and is 0 in IDLE.

Test Plan:
- Basic 16-pt (LOG2N=4, BFLY_LAT=2): pulse i_start -> 8 issues per stage, 2 gap cycles between stages; o_cycle_done in cycle 41 after the start edge; o_frame_cnt = 1.
- Address spot checks: s=0 idx=5 -> a=10, b=11, tw=0; s=1 idx=3 -> a=5, b=7, tw=4; s=3 idx=5 -> a=5, b=13, tw=5. Scoreboard all 32 triples against a model.
- Stall: i_stall high for 3 cycles during stage 2 -> idx frozen, o_issue low; o_cycle_done in cycle 44. i_stall during DRAIN has no effect.
- Abort/start interaction:
  - i_abort at stage 1 idx 4 -> next cycle IDLE; all outputs 0 except o_frame_cnt; no done pulse.
  - A subsequent i_start runs a full transform.
  - i_start pulses while busy are ignored.
- Async reset mid-RUN: deassert i_rst_n between clock edges -> outputs 0 immediately without a clock edge; o_frame_cnt=0; after release, idle until i_start.
- Parametrisation: LOG2N=3, BFLY_LAT=0 -> 3 stages x 4 issues back-to-back, no gaps; o_cycle_done in cycle 13. Continuous i_start -> next first issue 2 cycles after done. Run 256 frames -> o_frame_cnt wraps to 0.
